// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer.
// Optional perf counters are enabled by defining PC_SEQ_PERF_COUNT_EN.
package pc_seq_pkg;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BEQ  = 2'b01;
    localparam logic [1:0] PCSRC_BNE  = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: sequential, beq/bne on Zero, or jump.
// Also reports whether the selected branch is taken.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] CurPC,
    input  logic [1:0]  PCSrc,
    input  logic        Zero,
    input  logic [31:0] ImmediateExt,
    input  logic [25:0] JumpAddr,
    output logic [31:0] PCPlus4,
    output logic [31:0] NextPC,
    output logic        BrTaken
);

    logic [31:0] offset;
    logic [31:0] br_target;

    assign PCPlus4   = CurPC + 32'd4;
    assign offset    = ImmediateExt << 2;
    assign br_target = PCPlus4 + offset;

    // Pick the next PC and flag taken conditional branches
    always_comb begin
        NextPC  = PCPlus4;
        BrTaken = 1'b0;
        unique case (PCSrc)
            PCSRC_SEQ: NextPC = PCPlus4;
            PCSRC_BEQ: begin
                BrTaken = Zero;
                NextPC  = Zero ? br_target : PCPlus4;
            end
            PCSRC_BNE: begin
                BrTaken = ~Zero;
                NextPC  = Zero ? PCPlus4 : br_target;
            end
            PCSRC_JUMP: NextPC = {PCPlus4[31:28], JumpAddr, 2'b00};
            default: NextPC = PCPlus4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register plus BOOT/FETCH/EXEC/HALT sequencer with fetch handshake.
// Define PC_SEQ_PERF_COUNT_EN to build the instruction/branch counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                PCWre,
    input  logic [1:0]          PCSrc,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] ImmediateExt,
    input  logic [25:0]         JumpAddr,
    input  logic                InstrReady,
    output logic [PC_WIDTH-1:0] CurPC,
    output logic [PC_WIDTH-1:0] PCPlus4,
    output logic [PC_WIDTH-1:0] NextPC,
    output logic                InstrFetchReq,
    output logic                Halted,
    output logic                BranchTaken,
    output logic [31:0]         InstrCount,
    output logic [31:0]         BranchCount
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        bt_q, bt_d;
    logic        commit;
    logic        br_taken;

    next_pc_calc u_calc (
        .CurPC        (pc_q),
        .PCSrc        (PCSrc),
        .Zero         (Zero),
        .ImmediateExt (ImmediateExt),
        .JumpAddr     (JumpAddr),
        .PCPlus4      (PCPlus4),
        .NextPC       (NextPC),
        .BrTaken      (br_taken)
    );

    // State, PC and branch-pulse registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            bt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bt_q    <= bt_d;
        end
    end

    // Next-state: boot once, wait for fetch, execute, or park in halt
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: state_d = InstrReady ? S_EXEC : S_FETCH;
            S_EXEC:  state_d = PCWre ? S_FETCH : S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs and PC commit decided from the current state
    always_comb begin
        InstrFetchReq = (state_q == S_FETCH);
        Halted        = (state_q == S_HALT);
        commit        = (state_q == S_EXEC) && PCWre;
        pc_d          = commit ? {NextPC[31:2], 2'b00} : pc_q;
        bt_d          = commit && br_taken;
    end

    assign CurPC       = pc_q;
    assign BranchTaken = bt_q;

`ifdef PC_SEQ_PERF_COUNT_EN
    logic [31:0] ic_q, bc_q;

    // Saturating counters of executed instructions and taken branches
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            ic_q <= 32'd0;
            bc_q <= 32'd0;
        end else begin
            if (commit && ic_q != 32'hFFFF_FFFF)
                ic_q <= ic_q + 32'd1;
            if (bt_d && bc_q != 32'hFFFF_FFFF)
                bc_q <= bc_q + 32'd1;
        end
    end

    assign InstrCount  = ic_q;
    assign BranchCount = bc_q;
`else
    assign InstrCount  = 32'd0;
    assign BranchCount = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle model and literal checkpoints.
// Counter expectations follow PC_SEQ_PERF_COUNT_EN when defined.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        Zero;
    logic [31:0] ImmediateExt;
    logic [25:0] JumpAddr;
    logic        InstrReady;
    logic [31:0] CurPC, PCPlus4, NextPC;
    logic        InstrFetchReq, Halted, BranchTaken;
    logic [31:0] InstrCount, BranchCount;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.RESET_PC(32'h0)) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .PCWre         (PCWre),
        .PCSrc         (PCSrc),
        .Zero          (Zero),
        .ImmediateExt  (ImmediateExt),
        .JumpAddr      (JumpAddr),
        .InstrReady    (InstrReady),
        .CurPC         (CurPC),
        .PCPlus4       (PCPlus4),
        .NextPC        (NextPC),
        .InstrFetchReq (InstrFetchReq),
        .Halted        (Halted),
        .BranchTaken   (BranchTaken),
        .InstrCount    (InstrCount),
        .BranchCount   (BranchCount)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Spec arithmetic: target of each PCSrc choice, modulo 2^32
    function automatic logic [31:0] want_next(input logic [31:0] pc,
            input logic [1:0] src, input logic z,
            input logic [31:0] imm, input logic [25:0] ja);
        logic [31:0] seq;
        logic [31:0] br;
        seq = pc + 32'd4;
        br  = seq + imm * 32'd4;
        case (src)
            2'd0: return seq;
            2'd1: return z ? br : seq;
            2'd2: return z ? seq : br;
            default: return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
        endcase
    endfunction

    localparam int P_BOOT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_HALT  = 3;

    int          m_phase;
    logic [31:0] m_pc;
    logic        m_bt;
    longint      m_ic, m_bc;

    // Reference behaviour advanced on each rising edge
    always @(posedge CLK) begin
        if (!Reset) begin
            m_phase <= P_BOOT;
            m_pc    <= 32'h0;
            m_bt    <= 1'b0;
            m_ic    <= 0;
            m_bc    <= 0;
        end else begin
            m_bt <= 1'b0;
            if (m_phase == P_BOOT) begin
                m_phase <= P_FETCH;
            end else if (m_phase == P_FETCH) begin
                if (InstrReady) m_phase <= P_EXEC;
            end else if (m_phase == P_EXEC) begin
                if (PCWre) begin
                    m_phase <= P_FETCH;
                    m_pc    <= want_next(m_pc, PCSrc, Zero,
                                         ImmediateExt, JumpAddr);
                    m_ic    <= (m_ic < 64'hFFFF_FFFF) ? m_ic + 1 : m_ic;
                    if ((PCSrc == 2'd1 && Zero) || (PCSrc == 2'd2 && !Zero)) begin
                        m_bt <= 1'b1;
                        m_bc <= (m_bc < 64'hFFFF_FFFF) ? m_bc + 1 : m_bc;
                    end
                end else begin
                    m_phase <= P_HALT;
                end
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("CurPC", CurPC, m_pc);
            chk("PCPlus4", PCPlus4, m_pc + 32'd4);
            chk("NextPC", NextPC,
                want_next(m_pc, PCSrc, Zero, ImmediateExt, JumpAddr));
            chk("InstrFetchReq", {31'd0, InstrFetchReq},
                {31'd0, m_phase == P_FETCH});
            chk("Halted", {31'd0, Halted}, {31'd0, m_phase == P_HALT});
            chk("BranchTaken", {31'd0, BranchTaken}, {31'd0, m_bt});
`ifdef PC_SEQ_PERF_COUNT_EN
            chk("InstrCount", InstrCount, m_ic[31:0]);
            chk("BranchCount", BranchCount, m_bc[31:0]);
`else
            chk("InstrCount", InstrCount, 32'd0);
            chk("BranchCount", BranchCount, 32'd0);
`endif
        end
    end

    // One instruction: FETCH with ready, then EXEC with these controls
    task automatic instr(input logic we, input logic [1:0] src,
                         input logic z, input logic [31:0] imm,
                         input logic [25:0] ja);
        PCWre        = we;
        PCSrc        = src;
        Zero         = z;
        ImmediateExt = imm;
        JumpAddr     = ja;
        InstrReady   = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset        = 1'b0;
        PCWre        = 1'b1;
        PCSrc        = 2'd0;
        Zero         = 1'b0;
        ImmediateExt = 32'h0;
        JumpAddr     = 26'h0;
        InstrReady   = 1'b1;

        @(posedge CLK);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst CurPC", CurPC, 32'h0);
        chk("rst req", {31'd0, InstrFetchReq}, 32'd0);
        chk("rst halted", {31'd0, Halted}, 32'd0);

        Reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("boot->fetch req", {31'd0, InstrFetchReq}, 32'd1);

        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("seq 4", CurPC, 32'h4);
        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("seq 8", CurPC, 32'h8);
        instr(1'b1, 2'd3, 1'b0, 32'h0, 26'h8);
        chk("jump 20", CurPC, 32'h20);

        instr(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFE, 26'h0);
        chk("beq back", CurPC, 32'h1C);
        chk("beq pulse", {31'd0, BranchTaken}, 32'd1);
        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("seq 20", CurPC, 32'h20);
        instr(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFE, 26'h0);
        chk("beq not taken", CurPC, 32'h24);
        chk("beq no pulse", {31'd0, BranchTaken}, 32'd0);

        instr(1'b1, 2'd1, 1'b1, 32'h0400_0006, 26'h0);
        chk("beq far", CurPC, 32'h1000_0040);
        instr(1'b1, 2'd3, 1'b1, 32'h0, 26'h0000010);
        chk("jump region", CurPC, 32'h1000_0040);
        chk("jump no pulse", {31'd0, BranchTaken}, 32'd0);

        instr(1'b1, 2'd2, 1'b0, 32'h3BFF_FFEE, 26'h0);
        chk("bne top", CurPC, 32'hFFFF_FFFC);
        chk("bne pulse", {31'd0, BranchTaken}, 32'd1);
        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("wrap", CurPC, 32'h0);
        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("seq after wrap", CurPC, 32'h4);

        InstrReady = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("wait pc", CurPC, 32'h4);
            chk("wait req", {31'd0, InstrFetchReq}, 32'd1);
        end
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        chk("wait rst pc", CurPC, 32'h0);
        chk("wait rst req", {31'd0, InstrFetchReq}, 32'd0);
        Reset = 1'b1;
        InstrReady = 1'b1;
        @(posedge CLK);
        #1;

        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("post rst 4", CurPC, 32'h4);
        instr(1'b1, 2'd0, 1'b0, 32'h0, 26'h0);
        chk("post rst 8", CurPC, 32'h8);
        instr(1'b0, 2'd1, 1'b1, 32'h10, 26'h0);
        chk("halt pc", CurPC, 32'h8);
        chk("halt flag", {31'd0, Halted}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            InstrReady = i[0];
            @(posedge CLK);
            #1;
            chk("halt hold pc", CurPC, 32'h8);
            chk("halt hold req", {31'd0, InstrFetchReq}, 32'd0);
        end
`ifdef PC_SEQ_PERF_COUNT_EN
        chk("icount 2", InstrCount, 32'd2);
        chk("bcount 0", BranchCount, 32'd0);
`else
        chk("icount tied", InstrCount, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage that sits directly downstream of the ALU's zero flag and feeds the instruction-fetch path.
- Holds the current PC and runs a small fetch/execute state machine with an instruction-memory ready handshake.
- At the end of each execute cycle it commits the next PC: sequential, conditional branch on the ALU zero flag, or jump.
- Provides halt detection and a taken-branch indication to the rest of the CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_WIDTH, 32, width of every PC-related bus; fixed at 32 in this CPU.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- PCWre  in  1  CU write enable; 0 during EXEC marks a halt instruction.
- PCSrc  in  2  next-PC select: 00 seq, 01 beq, 10 bne, 11 jump.
- Zero  in  1  ALU zero flag; sampled only in EXEC.
- ImmediateExt  in  32  sign-extended 16-bit branch offset, in words.
- JumpAddr  in  26  jump target field.
- InstrReady  in  1  instruction memory has delivered the word at CurPC.
- CurPC  out  32  registered current PC.
- PCPlus4  out  32  CurPC+4, combinational.
- NextPC  out  32  combinational next-PC preview.
- InstrFetchReq  out  1  fetch request for CurPC.
- Halted  out  1  sticky halt indication.
- BranchTaken  out  1  one-cycle registered pulse when a beq/bne is taken.

Behaviour:
- Reset (Reset=0 at a rising edge, in any state):
  - State <= BOOT, CurPC <= RESET_PC.
  - InstrFetchReq=0, Halted=0, BranchTaken=0.
  - A reset during a fetch wait or in HALT is fully honoured; pending fetches are abandoned.
- States and transitions:
  - BOOT: exactly 1 cycle, request low, then FETCH.
  - FETCH: InstrFetchReq=1; stay until InstrReady=1, then EXEC. No timeout; waits indefinitely.
  - EXEC: exactly 1 cycle; InstrFetchReq=0. If PCWre=1: CurPC <= NextPC, go to FETCH. If PCWre=0: CurPC holds, go to HALT.
  - HALT: Halted=1, InstrFetchReq=0; sticky until reset.
- InstrReady is ignored outside FETCH.
- Fetch latency: minimum 2 cycles per instruction (FETCH with InstrReady=1, then EXEC).
- NextPC arithmetic, modulo 2^32, wrap-around silent:
  - 00: PCPlus4.
  - 01: Zero=1 gives PCPlus4 + (ImmediateExt<<2); otherwise PCPlus4.
  - 10: Zero=0 gives PCPlus4 + (ImmediateExt<<2); otherwise PCPlus4.
  - 11: {PCPlus4[31:28], JumpAddr, 2'b00}.
- Negative offsets are handled by two's-complement add.
- Zero and PCSrc are don't-care outside EXEC.
- BranchTaken is registered: 1 for the cycle after an EXEC that committed a taken 01/10 branch. Jumps and PCWre=0 never set it.
- CurPC[1:0] is always 00.

Optional Feature:
- Macro: PC_SEQ_PERF_COUNT_EN.
- With the macro defined:
  - Adds two 32-bit saturating counters, InstrCount (outputs, 32 bits each) and BranchCount.
  - Both counters clear on reset.
  - InstrCount increments on every EXEC with PCWre=1.
  - BranchCount increments whenever BranchTaken is set.
  - Both counters hold at 32'hFFFF_FFFF once reached.
- Without the macro: the ports exist and are tied to 0; no counter flops are built.

Decomposition:
- Package pc_seq_pkg holds:
  - PCSrc encodings PCSRC_SEQ / PCSRC_BEQ / PCSRC_BNE / PCSRC_JUMP.
  - State encodings S_BOOT / S_FETCH / S_EXEC / S_HALT.
  - Default RESET_PC.
- One sub-module, next_pc_calc: purely combinational. It takes CurPC, PCSrc, Zero, ImmediateExt and JumpAddr, and produces PCPlus4, NextPC and a branch-taken term.
- The FSM, PC register and optional counters stay in pc_sequencer.

Test Plan:
- Release reset with InstrReady held 1 and PCSrc=00, PCWre=1 → CurPC = 0, 4, 8 in successive EXEC cycles; InstrFetchReq toggles 0,1,0,1 after BOOT.
- At CurPC=0x20, PCSrc=01, Zero=1, ImmediateExt=0xFFFF_FFFE → CurPC becomes 0x1C and BranchTaken pulses once. Same with Zero=0 → CurPC becomes 0x24, no pulse.
- At CurPC=0x1000_0040, PCSrc=11, JumpAddr=26'h0000010 → CurPC becomes 0x1000_0040, no BranchTaken.
- At CurPC=0xFFFF_FFFC, PCSrc=00 → CurPC wraps to 0x0000_0000.
- InstrReady low for 5 cycles in FETCH → CurPC stable and InstrFetchReq=1 throughout. Assert Reset=0 on cycle 3 of the wait → next cycle CurPC=RESET_PC, state BOOT, request 0.
- EXEC with PCWre=0 at CurPC=0x8 → Halted=1 and CurPC stays 0x8 for 10+ cycles despite InstrReady toggling. With PC_SEQ_PERF_COUNT_EN, InstrCount=2 after executing 0x0 and 0x4.
